sha256_digest_check: RTL and testbench

Downstream consumer of the `sha256` core's serial output. It deserializes the 26 × 10-bit digest words (MSB-first, 256-bit digest plus 4 zero pad bits) into a 256-bit digest. It then compares the digest, unsigned, against a 256-bit target latched at arm time. It presents digest, hit flag and pad error to the mining controller through a valid/ready result handshake, and keeps a saturating hit counter.

---
 rtl/sha256_pkg.sv | 18 +
 rtl/sha256_digest_check_if.sv | 31 +++
 rtl/sha256_word_deser.sv | 44 ++++
 rtl/sha256_digest_check.sv | 108 ++++++++++
 tb/tb_sha256_digest_check.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// Shared constants and the state type for the sha256 digest checker.
package sha256_pkg;

  localparam int WORD_W    = 10;
  localparam int NWORDS    = 26;
  localparam int DIGEST_W  = 256;
  localparam int STREAM_W  = NWORDS * WORD_W;
  localparam int PAD_W     = STREAM_W - DIGEST_W;
  localparam int CNT_IDX_W = $clog2(NWORDS + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMPARE = 2'd2,
    HOLD    = 2'd3
  } chk_state_t;

endpackage

// File: rtl/sha256_digest_check_if.sv
// Arm, serial-word and result handshake bundle between the hash core,
// the mining controller and the digest checker.
interface sha256_digest_check_if #(
  parameter int WORD_W   = sha256_pkg::WORD_W,
  parameter int DIGEST_W = sha256_pkg::DIGEST_W,
  parameter int CNT_W    = 16
);

  logic                start;
  logic [DIGEST_W-1:0] target;
  logic                valid_in;
  logic [WORD_W-1:0]   hash_in;
  logic                result_ready;
  logic                result_valid;
  logic [DIGEST_W-1:0] digest;
  logic                hit;
  logic                pad_err;
  logic                busy;
  logic [CNT_W-1:0]    hit_count;

  modport master (
    output start, target, valid_in, hash_in, result_ready,
    input  result_valid, digest, hit, pad_err, busy, hit_count
  );

  modport slave (
    input  start, target, valid_in, hash_in, result_ready,
    output result_valid, digest, hit, pad_err, busy, hit_count
  );

endinterface

// File: rtl/sha256_word_deser.sv
// MSB-first deserializer: shifts accepted words into a stream buffer and
// counts them; the caller decides which beats are accepted.
module sha256_word_deser #(
  parameter int WORD_W = sha256_pkg::WORD_W,
  parameter int NWORDS = sha256_pkg::NWORDS
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_clear,
  input  logic                              i_valid,
  input  logic [WORD_W-1:0]                 i_word,
  output logic [NWORDS*WORD_W-1:0]          o_stream,
  output logic [$clog2(NWORDS+1)-1:0]       o_count,
  output logic                              o_full
);

  localparam int L_STREAM_W = NWORDS * WORD_W;
  localparam int L_IDX_W    = $clog2(NWORDS + 1);

  logic [L_STREAM_W-1:0] r_stream;
  logic [L_IDX_W-1:0]    r_count;

  // NOTE: reset is sampled on the clock edge, so it lives inside the
  // clocked branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stream <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_stream <= '0;
      r_count  <= '0;
    end else if (i_valid) begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of its neighbours.
      r_stream <= {r_stream[L_STREAM_W-WORD_W-1:0], i_word};
      r_count  <= r_count + 1'b1;
    end
  end

  assign o_stream = r_stream;
  assign o_count  = r_count;
  assign o_full   = (r_count == L_IDX_W'(NWORDS));

endmodule

// File: rtl/sha256_digest_check.sv
// Assembles the serial digest, compares it against the armed target and
// offers the result through a valid/ready handshake with a hit counter.
module sha256_digest_check #(
  parameter int WORD_W   = sha256_pkg::WORD_W,
  parameter int NWORDS   = sha256_pkg::NWORDS,
  parameter int DIGEST_W = sha256_pkg::DIGEST_W,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sha256_digest_check_if.slave  bus
);

  import sha256_pkg::*;

  localparam int L_STREAM_W = NWORDS * WORD_W;
  localparam int L_PAD_W    = L_STREAM_W - DIGEST_W;
  localparam int L_IDX_W    = $clog2(NWORDS + 1);

  chk_state_t            r_state;
  chk_state_t            w_state_nxt;
  logic                  w_accept;
  logic                  w_full;
  logic [L_STREAM_W-1:0] w_stream;
  logic [L_IDX_W-1:0]    w_count;
  logic [DIGEST_W-1:0]   w_stream_digest;
  logic                  w_stream_pad_err;
  logic                  w_hit;

  logic [DIGEST_W-1:0]   r_target;
  logic [DIGEST_W-1:0]   r_digest;
  logic                  r_hit;
  logic                  r_pad_err;
  logic [CNT_W-1:0]      r_hit_count;

  sha256_word_deser #(
    .WORD_W (WORD_W),
    .NWORDS (NWORDS)
  ) u_deser (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (bus.start),
    .i_valid  (w_accept),
    .i_word   (bus.hash_in),
    .o_stream (w_stream),
    .o_count  (w_count),
    .o_full   (w_full)
  );

  assign w_stream_digest  = w_stream[L_STREAM_W-1 -: DIGEST_W];
  assign w_stream_pad_err = |w_stream[L_PAD_W-1:0];
  assign w_hit            = (w_stream_digest < r_target);

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    if (bus.start) begin
      // Re-arm wins over everything, and the coincident word is dropped.
      w_state_nxt = COLLECT;
    end else begin
      case (r_state)
        IDLE: ;
        COLLECT: begin
          if (bus.valid_in && !w_full) begin
            w_accept = 1'b1;
            if (w_count == L_IDX_W'(NWORDS - 1)) w_state_nxt = COMPARE;
          end
        end
        COMPARE: w_state_nxt = HOLD;
        HOLD:    if (bus.result_ready) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_target    <= '0;
      r_digest    <= '0;
      r_hit       <= 1'b0;
      r_pad_err   <= 1'b0;
      r_hit_count <= '0;
    end else begin
      if (bus.start) r_target <= bus.target;
      if (r_state == COMPARE && !bus.start) begin
        r_digest  <= w_stream_digest;
        r_hit     <= w_hit;
        r_pad_err <= w_stream_pad_err;
        if (w_hit && r_hit_count != '1) r_hit_count <= r_hit_count + 1'b1;
      end
    end
  end

  assign bus.result_valid = (r_state == HOLD);
  assign bus.busy         = (r_state != IDLE);
  assign bus.digest       = r_digest;
  assign bus.hit          = r_hit;
  assign bus.pad_err      = r_pad_err;
  assign bus.hit_count    = r_hit_count;

endmodule

// File: tb/tb_sha256_digest_check.sv
// Directed bench for sha256_digest_check; a 4-bit-counter twin shares the
// stimulus so hit-counter saturation is reachable in a short run.
module tb_sha256_digest_check;

  localparam int DW = 256;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  sha256_digest_check_if #(.CNT_W(16)) m_if ();
  sha256_digest_check_if #(.CNT_W(4))  s_if ();

  assign s_if.start        = m_if.start;
  assign s_if.target       = m_if.target;
  assign s_if.valid_in     = m_if.valid_in;
  assign s_if.hash_in      = m_if.hash_in;
  assign s_if.result_ready = m_if.result_ready;

  sha256_digest_check #(.CNT_W(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m_if.slave)
  );

  sha256_digest_check #(.CNT_W(4)) u_dut_small (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (s_if.slave)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic arm(input logic [DW-1:0] tgt);
    m_if.start    = 1'b1;
    m_if.target   = tgt;
    m_if.valid_in = 1'b0;
    tick();
    m_if.start    = 1'b0;
  endtask

  task automatic feed(input logic [9:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      m_if.valid_in = 1'b1;
      m_if.hash_in  = w;
      tick();
    end
    m_if.valid_in = 1'b0;
  endtask

  task automatic wait_result(input string name);
    for (int i = 0; i < 8 && !m_if.result_valid; i++) tick();
    checks++;
    if (m_if.result_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: result_valid=%b required 1", name, m_if.result_valid);
    end
  endtask

  task automatic accept(input string name);
    m_if.result_ready = 1'b1;
    tick();
    m_if.result_ready = 1'b0;
    checks++;
    if (m_if.result_valid !== 1'b0 || m_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: result_valid=%b busy=%b required 0 0",
               name, m_if.result_valid, m_if.busy);
    end
  endtask

  task automatic test_reset();
    rst_n             = 1'b0;
    m_if.start        = 1'b0;
    m_if.target       = '0;
    m_if.valid_in     = 1'b0;
    m_if.hash_in      = '0;
    m_if.result_ready = 1'b0;
    tick();
    tick();
    checks++;
    if ({m_if.result_valid, m_if.hit, m_if.pad_err, m_if.busy} !== 4'b0 ||
        m_if.digest !== '0 || m_if.hit_count !== 16'd0) begin
      errors++;
      $display("FAIL reset: rv=%b hit=%b pad=%b busy=%b cnt=%0d digest=%h required all 0",
               m_if.result_valid, m_if.hit, m_if.pad_err, m_if.busy, m_if.hit_count, m_if.digest);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_zero_hit();
    arm(256'h1);
    checks++;
    if (m_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL zero busy: busy=%b required 1", m_if.busy);
    end
    feed(10'h000, 26);
    checks++;
    if (m_if.result_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero latency1: result_valid=%b required 0", m_if.result_valid);
    end
    tick();
    exp_cnt++;
    checks++;
    if (m_if.result_valid !== 1'b1 || m_if.digest !== '0 || m_if.hit !== 1'b1 ||
        m_if.pad_err !== 1'b0 || m_if.hit_count !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL zero result: rv=%b hit=%b pad=%b cnt=%0d digest=%h required 1 1 0 %0d 0",
               m_if.result_valid, m_if.hit, m_if.pad_err, m_if.hit_count, m_if.digest, exp_cnt);
    end
    accept("zero");
    checks++;
    if (m_if.digest !== '0 || m_if.hit !== 1'b1) begin
      errors++;
      $display("FAIL zero retain: hit=%b digest=%h required 1 0", m_if.hit, m_if.digest);
    end
  endtask

  task automatic test_equal();
    arm({DW{1'b1}});
    feed(10'h3FF, 25);
    feed(10'h3F0, 1);
    wait_result("equal");
    checks++;
    if (m_if.digest !== {DW{1'b1}} || m_if.hit !== 1'b0 || m_if.pad_err !== 1'b0 ||
        m_if.hit_count !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL equal: hit=%b pad=%b cnt=%0d digest=%h required 0 0 %0d all-ones",
               m_if.hit, m_if.pad_err, m_if.hit_count, m_if.digest, exp_cnt);
    end
    accept("equal");
  endtask

  task automatic test_pad();
    arm({DW{1'b1}});
    feed(10'h000, 25);
    feed(10'h001, 1);
    wait_result("pad");
    exp_cnt++;
    checks++;
    if (m_if.digest !== '0 || m_if.pad_err !== 1'b1 || m_if.hit !== 1'b1 ||
        m_if.hit_count !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL pad: pad=%b hit=%b cnt=%0d digest=%h required 1 1 %0d 0",
               m_if.pad_err, m_if.hit, m_if.hit_count, m_if.digest, exp_cnt);
    end
    accept("pad");
  endtask

  task automatic test_rearm();
    logic [DW-1:0] exp_d;
    exp_d = {64{4'h5}};
    arm('0);
    feed(10'h3FF, 10);
    m_if.start    = 1'b1;
    m_if.target   = {4'h6, 252'h0};
    m_if.valid_in = 1'b1;
    m_if.hash_in  = 10'h3FF;
    tick();
    m_if.start    = 1'b0;
    m_if.valid_in = 1'b0;
    feed(10'h155, 26);
    wait_result("rearm");
    exp_cnt++;
    checks++;
    if (m_if.digest !== exp_d || m_if.hit !== 1'b1 || m_if.pad_err !== 1'b1 ||
        m_if.hit_count !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL rearm: hit=%b pad=%b cnt=%0d digest=%h required 1 1 %0d %h",
               m_if.hit, m_if.pad_err, m_if.hit_count, m_if.digest, exp_cnt, exp_d);
    end
    accept("rearm");
  endtask

  task automatic test_gaps_hold();
    logic [259:0]  exp_s;
    logic [DW-1:0] exp_d;
    logic          exp_p;
    logic [9:0]    w;
    exp_s = '0;
    arm('0);
    for (int k = 0; k < 26; k++) begin
      w = 10'(k * 37 + 5);
      exp_s = {exp_s[249:0], w};
      if (k % 3 == 0) tick();
      feed(w, 1);
    end
    exp_d = exp_s[259:4];
    exp_p = |exp_s[3:0];
    m_if.valid_in = 1'b1;
    m_if.hash_in  = 10'h3FF;
    for (int i = 0; i < 5; i++) tick();
    m_if.valid_in = 1'b0;
    checks++;
    if (m_if.result_valid !== 1'b1 || m_if.busy !== 1'b1 || m_if.digest !== exp_d ||
        m_if.pad_err !== exp_p || m_if.hit !== 1'b0) begin
      errors++;
      $display("FAIL gaps result: rv=%b busy=%b hit=%b pad=%b digest=%h required 1 1 0 %b %h",
               m_if.result_valid, m_if.busy, m_if.hit, m_if.pad_err, m_if.digest, exp_p, exp_d);
    end
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (m_if.result_valid !== 1'b1 || m_if.digest !== exp_d) begin
        errors++;
        $display("FAIL hold stable cycle %0d: rv=%b digest=%h required 1 %h",
                 i, m_if.result_valid, m_if.digest, exp_d);
      end
    end
    accept("gaps");
    checks++;
    if (m_if.digest !== exp_d || m_if.hit_count !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL gaps retain: cnt=%0d digest=%h required %0d %h",
               m_if.hit_count, m_if.digest, exp_cnt, exp_d);
    end
  endtask

  task automatic test_back_to_back_sat();
    int exp_small;
    m_if.result_ready = 1'b1;
    for (int n = 0; n < 14; n++) begin
      arm({DW{1'b1}});
      feed(10'h000, 26);
      tick();
      exp_cnt++;
      exp_small = (exp_cnt > 15) ? 15 : exp_cnt;
      checks++;
      if (m_if.result_valid !== 1'b1 || m_if.hit_count !== 16'(exp_cnt) ||
          s_if.hit_count !== 4'(exp_small)) begin
        errors++;
        $display("FAIL b2b run %0d: rv=%b cnt=%0d small=%0d required 1 %0d %0d",
                 n, m_if.result_valid, m_if.hit_count, s_if.hit_count, exp_cnt, exp_small);
      end
      tick();
      checks++;
      if (m_if.result_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b pulse %0d: rv=%b required 0", n, m_if.result_valid);
      end
    end
    m_if.result_ready = 1'b0;
    checks++;
    if (s_if.hit_count !== 4'hF) begin
      errors++;
      $display("FAIL saturate: small hit_count=%0d required 15", s_if.hit_count);
    end
  endtask

  task automatic test_reset_in_hold();
    arm({DW{1'b1}});
    feed(10'h000, 26);
    tick();
    checks++;
    if (m_if.result_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre-reset hold: rv=%b required 1", m_if.result_valid);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({m_if.result_valid, m_if.hit, m_if.pad_err, m_if.busy} !== 4'b0 ||
        m_if.digest !== '0 || m_if.hit_count !== 16'd0 || s_if.hit_count !== 4'd0) begin
      errors++;
      $display("FAIL reset in hold: rv=%b hit=%b pad=%b busy=%b cnt=%0d small=%0d required all 0",
               m_if.result_valid, m_if.hit, m_if.pad_err, m_if.busy, m_if.hit_count,
               s_if.hit_count);
    end
    rst_n = 1'b1;
    exp_cnt = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_zero_hit();
    test_equal();
    test_pad();
    test_rearm();
    test_gaps_hold();
    test_back_to_back_sat();
    test_reset_in_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
